fact_mmio_slave: RTL and testbench

Memory-mapped factorial accelerator. It is the responder for the SoC address window 0x800-0x8FF.
- The SoC decoder drives this block's WE from its accelerator write-enable (WE1).
- It routes this block's RD to the CPU when RdSel = 2'b10.
- Internally it holds a register file (n, Go, status, result) and an iterative multiply FSM that computes n! one multiply per cycle.

---
 rtl/fact_pkg.sv | 25 ++
 rtl/fact_core.sv | 103 ++++++++++
 rtl/fact_mmio_slave.sv | 75 +++++++
 tb/tb_fact_mmio_slave.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// ============================================================================
// Module   : fact_pkg
// Brief    : Register offsets, FSM encoding and operand limit shared by the
//            factorial accelerator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fact_pkg;

  localparam logic [1:0] FACT_N   = 2'b00;
  localparam logic [1:0] FACT_GO  = 2'b01;
  localparam logic [1:0] FACT_ST  = 2'b10;
  localparam logic [1:0] FACT_RES = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Largest n whose factorial fits in a 32-bit result
  localparam int MAX_N = 12;

endpackage

`default_nettype wire

// File: rtl/fact_core.sv
// ============================================================================
// Module   : fact_core
// Brief    : Iterative factorial engine, one multiply per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fact_core #(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int MAX_N  = fact_pkg::MAX_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    n_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result
);

  import fact_pkg::*;

  localparam logic [N_W-1:0]    c_max_n = N_W'(MAX_N);
  localparam logic [N_W-1:0]    c_one   = N_W'(1);
  localparam logic [DATA_W-1:0] c_acc_1 = DATA_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] w_prod;
  logic [N_W-1:0]    r_cnt;
  logic              r_done;
  logic              r_err;
  logic              w_over;
  logic              w_last;
  logic              w_accept;

  assign w_over   = (r_cnt > c_max_n);
  assign w_last   = (r_cnt <= c_one);
  assign w_prod   = r_acc * {{(DATA_W-N_W){1'b0}}, r_cnt};
  assign w_accept = start && (r_state != ST_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_BUSY;
      ST_BUSY: if (w_over || w_last) w_next_state = ST_DONE;
      ST_DONE: if (start) w_next_state = ST_BUSY;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Out-of-range operands are only possible on the first BUSY cycle, since
  // cnt only ever counts down from an in-range value afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= c_acc_1;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_acc    <= c_acc_1;
      r_cnt    <= n_in;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == ST_BUSY) begin
      if (w_over) begin
        r_err    <= 1'b1;
        r_done   <= 1'b1;
        r_result <= '0;
      end else if (w_last) begin
        r_result <= r_acc;
        r_done   <= 1'b1;
      end else begin
        r_acc <= w_prod;
        r_cnt <= r_cnt - c_one;
      end
    end
  end

  always_comb begin
    busy   = (r_state == ST_BUSY);
    done   = r_done;
    err    = r_err;
    result = r_result;
  end

endmodule

`default_nettype wire

// File: rtl/fact_mmio_slave.sv
// ============================================================================
// Module   : fact_mmio_slave
// Brief    : Memory-mapped register front end for the factorial engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fact_mmio_slave #(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int MAX_N  = fact_pkg::MAX_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WE,
  input  logic [1:0]        A,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD
);

  import fact_pkg::*;

  logic [N_W-1:0]    r_n;
  logic              r_go;
  logic              w_busy;
  logic              w_done;
  logic              w_err;
  logic [DATA_W-1:0] w_result;
  logic              w_start;
  logic              w_unused;

  assign w_unused = &{1'b0, WD[DATA_W-1:N_W]};

  // The engine ignores start while busy anyway; gating here keeps intent local.
  assign w_start = WE && (A == FACT_GO) && WD[0] && !w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n  <= '0;
      r_go <= 1'b0;
    end else if (WE) begin
      if (A == FACT_N)  r_n  <= WD[N_W-1:0];
      if (A == FACT_GO) r_go <= WD[0];
    end
  end

  fact_core #(
    .DATA_W (DATA_W),
    .N_W    (N_W),
    .MAX_N  (MAX_N)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (w_start),
    .n_in   (r_n),
    .busy   (w_busy),
    .done   (w_done),
    .err    (w_err),
    .result (w_result)
  );

  always_comb begin
    RD = '0;
    case (A)
      FACT_N:   RD = {{(DATA_W-N_W){1'b0}}, r_n};
      FACT_GO:  RD = {{(DATA_W-1){1'b0}}, r_go};
      FACT_ST:  RD = {{(DATA_W-2){1'b0}}, w_err, w_done};
      FACT_RES: RD = w_result;
      default:  RD = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fact_mmio_slave.sv
// ============================================================================
// Module   : tb_fact_mmio_slave
// Brief    : Self-checking bench for fact_mmio_slave against a factorial model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fact_mmio_slave;

  localparam int DATA_W = 32;
  localparam int N_W    = 4;
  localparam int MAX_N  = 12;

  logic              clk;
  logic              rst;
  logic              WE;
  logic [1:0]        A;
  logic [DATA_W-1:0] WD;
  logic [DATA_W-1:0] RD;

  int n_tests = 0;
  int n_fail  = 0;
  int m_n     = 0;
  int m_go    = 0;

  fact_mmio_slave #(
    .DATA_W (DATA_W),
    .N_W    (N_W),
    .MAX_N  (MAX_N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .WE  (WE),
    .A   (A),
    .WD  (WD),
    .RD  (RD)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_fact(input int n);
    longint p = 1;
    if (n > MAX_N) return '0;
    for (int i = 2; i <= n; i++) p = p * i;
    return p[DATA_W-1:0];
  endfunction

  function automatic int ref_lat(input int n);
    return (n > MAX_N || n < 2) ? 1 : n;
  endfunction

  // One bus cycle: exactly one rising edge, reads possible right after
  task automatic cycle(input bit we, input logic [1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    WE = we; A = a; WD = d;
    @(posedge clk);
    #1;
    WE = 1'b0; WD = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
    cycle(1'b1, a, d);
    if (a == 2'b00) m_n  = int'(d[N_W-1:0]);
    if (a == 2'b01) m_go = int'(d[0]);
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [DATA_W-1:0] exp);
    A = a;
    #1;
    check(tag, RD, exp);
  endtask

  task automatic check_regs(input string tag);
    rd(2'b00, {tag, ".n"},  DATA_W'(m_n));
    rd(2'b01, {tag, ".go"}, DATA_W'(m_go));
  endtask

  // Start from the current model n; optional random bus traffic while busy
  task automatic start_and_track(input string tag, input bit noisy);
    int n_run;
    int lat;
    logic [DATA_W-1:0] exp_res;
    logic [DATA_W-1:0] exp_st;
    logic [1:0] a;
    logic [DATA_W-1:0] d;
    n_run   = m_n;
    lat     = ref_lat(n_run);
    exp_res = ref_fact(n_run);
    exp_st  = (n_run > MAX_N) ? DATA_W'(3) : DATA_W'(1);
    bus_write(2'b01, 1);
    rd(2'b10, {tag, ".st0"}, '0);
    rd(2'b11, {tag, ".res0"}, '0);
    for (int k = 1; k <= lat; k++) begin
      if (noisy && $urandom_range(0, 1) == 1) begin
        a = 2'($urandom_range(0, 3));
        d = DATA_W'($urandom);
        bus_write(a, d);
      end else begin
        cycle(1'b0, 2'($urandom_range(0, 3)), DATA_W'($urandom));
      end
      if (k < lat) begin
        rd(2'b10, {tag, ".st_busy"}, '0);
      end else begin
        rd(2'b10, {tag, ".st_done"}, exp_st);
        rd(2'b11, {tag, ".res"}, exp_res);
        check_regs(tag);
      end
    end
  endtask

  task automatic run(input string tag, input int n, input bit noisy);
    bus_write(2'b00, DATA_W'(n));
    start_and_track(tag, noisy);
  endtask

  initial begin
    rst = 1'b1; WE = 1'b0; A = '0; WD = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(2'b00, "rst.n", '0);
    rd(2'b01, "rst.go", '0);
    rd(2'b10, "rst.st", '0);
    rd(2'b11, "rst.res", '0);

    run("n5", 5, 1'b0);
    run("n0", 0, 1'b0);
    run("n1", 1, 1'b0);
    run("n12", 12, 1'b0);
    check(".n12const", ref_fact(12), 32'h1C8C_FC00);
    run("n13", 13, 1'b0);
    run("n15", 15, 1'b0);

    // Re-program while busy: running computation must use the latched operand
    bus_write(2'b00, 6);
    bus_write(2'b01, 1);
    for (int k = 1; k <= 6; k++) begin
      if (k == 1)      bus_write(2'b00, 3);
      else if (k == 2) bus_write(2'b01, 1);
      else             cycle(1'b0, 2'b00, '0);
      if (k < 6) rd(2'b10, "busywr.st_busy", '0);
    end
    rd(2'b10, "busywr.st_done", 1);
    rd(2'b11, "busywr.res", 720);
    check_regs("busywr");
    start_and_track("busywr2", 1'b0);

    // Read-only offsets and WE=0 traffic must not disturb anything
    run("ro", 5, 1'b0);
    cycle(1'b1, 2'b10, '1);
    cycle(1'b1, 2'b11, '1);
    cycle(1'b0, 2'b00, 7);
    cycle(1'b0, 2'b01, 1);
    rd(2'b10, "ro.st", 1);
    rd(2'b11, "ro.res", 120);
    check_regs("ro");
    bus_write(2'b01, 0);
    rd(2'b10, "go0.st", 1);
    rd(2'b11, "go0.res", 120);
    check_regs("go0");

    // Asynchronous reset from DONE and from mid-computation
    rst = 1'b1;
    #1;
    rd(2'b10, "rstdone.st", '0);
    rd(2'b11, "rstdone.res", '0);
    rd(2'b00, "rstdone.n", '0);
    @(negedge clk);
    rst = 1'b0; m_n = 0; m_go = 0;
    bus_write(2'b00, 12);
    bus_write(2'b01, 1);
    repeat (3) cycle(1'b0, 2'b00, '0);
    rst = 1'b1;
    #1;
    rd(2'b10, "rstbusy.st", '0);
    rd(2'b11, "rstbusy.res", '0);
    @(negedge clk);
    rst = 1'b0; m_n = 0; m_go = 0;
    bus_write(2'b01, 0);
    repeat (14) cycle(1'b0, 2'b00, '0);
    rd(2'b10, "idle.st", '0);
    rd(2'b11, "idle.res", '0);
    check_regs("idle");

    for (int it = 0; it < 40; it++) begin
      run("rand", $urandom_range(0, 15), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
